// File: rtl/controller_poller_if.sv
// controller_poller_if: serial pad bus shared by the poller and CHANNELS pads.
interface controller_poller_if #(
    parameter int CHANNELS = 2
);
    logic                controller_latch;
    logic                controller_clk;
    logic [CHANNELS-1:0] controller_data_in_B;
    modport master (output controller_latch, controller_clk, input controller_data_in_B);
    modport slave  (input controller_latch, controller_clk, output controller_data_in_B);
endinterface

// File: rtl/controller_poller_m.sv
// controller_poller_m: polls CHANNELS serial pads in parallel and publishes
// atomic snapshots plus sticky newly-pressed flags.
module controller_poller_m #(
    parameter int CHANNELS      = 2,
    parameter int BUTTONS       = 8,
    parameter int CLK_DIV       = 4,
    parameter bit DATA_INVERTED = 1'b1
) (
    input  logic                         clk_1,
    input  logic                         rst_B,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    controller_poller_if.master          pad,
    output logic [CHANNELS*BUTTONS-1:0]  buttons_out,
    output logic [CHANNELS*BUTTONS-1:0]  pressed_out,
    input  logic [CHANNELS-1:0]          pressed_clear
);
    localparam int N  = CHANNELS * BUTTONS;
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int BW = BUTTONS > 1 ? $clog2(BUTTONS) : 1;

    typedef enum logic [2:0] {IDLE, LATCH, CLK_HI, CLK_LO, DONE} state_t;

    state_t              state_q, state_d;
    logic [DW-1:0]       div_q, div_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [N-1:0]        cap_q, cap_d, buttons_q, buttons_d, pressed_q, pressed_d, rise_q, rise_d, clr_mask;
    logic                latch_q, clk_q, busy_q, done_q;
    logic                last, grab, enter_done;
    logic [CHANNELS-1:0] sample;

    assign sample     = DATA_INVERTED ? ~pad.controller_data_in_B : pad.controller_data_in_B;
    assign last       = div_q == DW'(CLK_DIV - 1);
    assign grab       = last && (state_q == LATCH || state_q == CLK_LO);
    assign enter_done = state_d == DONE && state_q != DONE;

    always_comb begin
        state_d = state_q;
        div_d   = (state_q == IDLE || state_q == DONE || last) ? '0 : div_q + 1'b1;
        bit_d   = state_q == IDLE ? '0 : bit_q;
        cap_d   = cap_q;
        case (state_q)
            IDLE:    state_d = start ? LATCH : IDLE;
            LATCH:   state_d = !last ? LATCH : (BUTTONS == 1 ? DONE : CLK_HI);
            CLK_HI:  state_d = last ? CLK_LO : CLK_HI;
            CLK_LO:  state_d = !last ? CLK_LO : (bit_q == BW'(BUTTONS - 1) ? DONE : CLK_HI);
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (grab)
            for (int c = 0; c < CHANNELS; c++) cap_d[c*BUTTONS + int'(bit_q)] = sample[c];
        if (last && state_d == CLK_HI) bit_d = bit_q + 1'b1;
    end

    always_comb begin
        clr_mask = '0;
        for (int c = 0; c < CHANNELS; c++) clr_mask[c*BUTTONS +: BUTTONS] = {BUTTONS{pressed_clear[c]}};
    end

    // rise_q replays the new flags during DONE so a clear issued in that cycle still loses to the set
    assign rise_d    = cap_d & ~buttons_q;
    assign buttons_d = enter_done ? cap_d : buttons_q;
    assign pressed_d = (pressed_q & ~clr_mask) | (enter_done ? rise_d : '0) | (state_q == DONE ? rise_q : '0);

    always_ff @(posedge clk_1 or negedge rst_B) begin
        if (!rst_B) begin
            state_q   <= IDLE;
            div_q     <= '0;
            bit_q     <= '0;
            cap_q     <= '0;
            buttons_q <= '0;
            pressed_q <= '0;
            rise_q    <= '0;
            latch_q   <= 1'b0;
            clk_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            cap_q     <= cap_d;
            buttons_q <= buttons_d;
            pressed_q <= pressed_d;
            rise_q    <= rise_d;
            latch_q   <= state_d == LATCH;
            clk_q     <= state_d == CLK_HI;
            busy_q    <= state_d != IDLE;
            done_q    <= state_d == DONE;
        end
    end

    assign busy                 = busy_q;
    assign done                 = done_q;
    assign pad.controller_latch = latch_q;
    assign pad.controller_clk   = clk_q;
    assign buttons_out          = buttons_q;
    assign pressed_out          = pressed_q;
endmodule

// File: tb/tb_controller_poller_m.sv
// tb_controller_poller_m: scoreboard bench for the pad poller with a behavioural
// NES pad model and a second small-parameter instance.
module tb_controller_poller_m;
    typedef struct {
        logic [15:0] b;
        logic [15:0] p;
    } exp_t;

    logic        clk_1 = 1'b0;
    logic        rst_B = 1'b0;
    logic        start = 1'b0;
    logic        start6 = 1'b0;
    logic [1:0]  pclr = 2'b00;
    logic        busy, done, busy6, done6;
    logic [15:0] buttons, pressed;
    logic [47:0] buttons6, pressed6;
    logic        absent = 1'b0;
    logic [7:0]  pv [2];
    logic [1:0]  pbit;
    int          idx = 0;
    logic        pclk = 1'b0;
    int          n_chk = 0, n_pass = 0;
    int          t_done, n_done, n_latch, n_rise, n_busy;
    logic [15:0] exp_bt = '0, exp_pr = '0;
    exp_t        exp_q[$];

    controller_poller_if #(.CHANNELS(2)) if0 ();
    controller_poller_if #(.CHANNELS(4)) if1 ();

    controller_poller_m dut (
        .clk_1(clk_1), .rst_B(rst_B), .start(start), .busy(busy), .done(done), .pad(if0),
        .buttons_out(buttons), .pressed_out(pressed), .pressed_clear(pclr)
    );

    controller_poller_m #(.CHANNELS(4), .BUTTONS(12), .CLK_DIV(1), .DATA_INVERTED(1'b1)) dut6 (
        .clk_1(clk_1), .rst_B(rst_B), .start(start6), .busy(busy6), .done(done6), .pad(if1),
        .buttons_out(buttons6), .pressed_out(pressed6), .pressed_clear(4'h0)
    );

    always #5 clk_1 = ~clk_1;

    // NES pad: transparent on bit 0 while latched, advances one bit per controller_clk rise
    always @(posedge clk_1) begin
        if (if0.controller_latch) idx <= 0;
        else if (if0.controller_clk && !pclk) idx <= idx + 1;
        pclk <= if0.controller_clk;
    end
    always_comb
        for (int c = 0; c < 2; c++) pbit[c] = if0.controller_latch ? pv[c][0] : (idx < 8 ? pv[c][idx] : 1'b1);
    assign if0.controller_data_in_B = absent ? 2'b11 : ~pbit;
    assign if1.controller_data_in_B = 4'hF;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(negedge clk_1)
        if (done) begin
            if (exp_q.size() == 0) check("sb_unexpected_done", 1, 0);
            else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_buttons", buttons, e.b);
                check("sb_pressed", pressed, e.p);
            end
        end

    task automatic run_poll(input logic [7:0] a, input logic [7:0] b, input logic [1:0] clr, input int extra);
        logic [15:0] nb, rise;
        exp_t        e;
        logic        pc;
        pv[0] = a;
        pv[1] = b;
        nb = absent ? 16'h0 : {b, a};
        rise = nb & ~exp_bt;
        e.b = nb;
        e.p = exp_pr | rise;
        exp_q.push_back(e);
        exp_pr = ((exp_pr | rise) & ~{{8{clr[1]}}, {8{clr[0]}}}) | rise;
        exp_bt = nb;
        t_done = -1; n_done = 0; n_latch = 0; n_rise = 0; n_busy = 0; pc = 1'b0;
        @(posedge clk_1); #1 start = 1'b1;
        for (int i = 0; i < 130; i++) begin
            @(negedge clk_1);
            if (i == 1 || (extra > 0 && i == extra + 1)) start = 1'b0;
            if (extra > 0 && i == extra) start = 1'b1;
            pclr = 2'b00;
            if (done) begin
                if (t_done < 0) t_done = i;
                n_done++;
                pclr = clr;
            end
            if (if0.controller_latch) n_latch++;
            if (if0.controller_clk && !pc) n_rise++;
            pc = if0.controller_clk;
            if (busy) n_busy++;
        end
        pclr = 2'b00;
    endtask

    task automatic clear_pads(input logic [1:0] m);
        @(negedge clk_1); pclr = m;
        @(negedge clk_1); pclr = 2'b00;
        exp_pr = exp_pr & ~{{8{m[1]}}, {8{m[0]}}};
        @(negedge clk_1);
        check("clear", pressed, exp_pr);
    endtask

    initial begin
        int t_prev, nd, t6, r6;
        logic pc6;
        pv[0] = 8'h00; pv[1] = 8'h00;
        repeat (3) @(negedge clk_1);
        check("rst_ctl", {busy, done, if0.controller_latch, if0.controller_clk}, 4'h0);
        check("rst_btn", buttons, 16'h0);
        check("rst_prs", pressed, 16'h0);
        check("rst_dut6", {busy6, done6, buttons6, pressed6}, '0);
        @(posedge clk_1); #1 rst_B = 1'b1;
        repeat (2) @(negedge clk_1);
        check("post_rst", {busy, done, if0.controller_latch, if0.controller_clk, buttons, pressed}, '0);

        run_poll(8'hA5, 8'h3C, 2'b00, -1);
        check("t2_done_cyc", t_done, 61);
        check("t2_ndone", n_done, 1);
        check("t2_latch", n_latch, 4);
        check("t2_rises", n_rise, 7);
        check("t2_busy", n_busy, 61);
        check("t2_btn", buttons, 16'h3CA5);

        run_poll(8'h00, 8'h00, 2'b00, -1);
        clear_pads(2'b11);
        run_poll(8'h01, 8'h00, 2'b00, -1);
        check("t3_first", pressed[7:0], 8'h01);
        run_poll(8'h03, 8'h00, 2'b00, -1);
        check("t3_sticky", pressed[7:0], 8'h03);
        clear_pads(2'b01);
        run_poll(8'h03, 8'h00, 2'b00, -1);
        check("t3_after_clr", pressed[7:0], 8'h00);

        run_poll(8'h00, 8'h00, 2'b00, -1);
        run_poll(8'h01, 8'h00, 2'b00, -1);
        run_poll(8'h05, 8'h00, 2'b01, -1);
        check("t4_set_wins", pressed[7:0], 8'h04);
        check("t4_model", pressed, exp_pr);

        for (int k = 0; k < 3; k++) begin
            exp_t e;
            e.b = exp_bt;
            e.p = exp_pr;
            exp_q.push_back(e);
        end
        t_prev = -1; nd = 0;
        @(posedge clk_1); #1 start = 1'b1;
        for (int i = 0; i < 400 && nd < 3; i++) begin
            @(negedge clk_1);
            if (done) begin
                if (nd > 0) check("t5_period", i - t_prev, 62);
                t_prev = i;
                nd++;
                if (nd == 3) start = 1'b0;
            end
        end
        check("t5_hold_polls", nd, 3);
        nd = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk_1);
            if (done) nd++;
        end
        check("t5_hold_stop", nd, 0);
        run_poll(8'h05, 8'h00, 2'b00, 20);
        check("t5_busy_start", n_done, 1);

        absent = 1'b1;
        run_poll(8'hFF, 8'hFF, 2'b00, -1);
        check("t6_absent", buttons, 16'h0);
        absent = 1'b0;

        t6 = -1; r6 = 0; pc6 = 1'b0;
        @(posedge clk_1); #1 start6 = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_1);
            if (i == 1) start6 = 1'b0;
            if (done6 && t6 < 0) t6 = i;
            if (if1.controller_clk && !pc6) r6++;
            pc6 = if1.controller_clk;
        end
        check("t6_done_cyc", t6, 24);
        check("t6_rises", r6, 11);
        check("t6_btn", buttons6, 48'h0);

        run_poll(8'h5A, 8'hC3, 2'b00, -1);
        check("pre_rst_btn", buttons, 16'hC35A);
        pv[0] = 8'hFF; pv[1] = 8'hFF;
        @(posedge clk_1); #1 start = 1'b1;
        nd = 0;
        for (int i = 0; i < 40 && !if0.controller_clk; i++) @(negedge clk_1);
        start = 1'b0;
        check("t1_in_clk_hi", if0.controller_clk, 1'b1);
        #2 rst_B = 1'b0;
        #1;
        check("t1_async", {if0.controller_clk, if0.controller_latch, busy}, 3'b000);
        check("t1_async_btn", buttons, 16'h0);
        @(posedge clk_1); #1 rst_B = 1'b1;
        exp_bt = '0; exp_pr = '0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_1);
            if (done || busy) nd++;
        end
        check("t1_no_resume", nd, 0);
        check("t1_btn_stays0", buttons, 16'h0);
        check("sb_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
